trap_ctrl: RTL and testbench

//  Pipeline-side trap sequencer; drives the trap/mret interface of the M-mode CSR register file.

---
 rtl/trap_ctrl_pkg.sv | 49 ++++
 rtl/trap_ctrl_if.sv | 42 ++++
 rtl/trap_ctrl.sv | 120 ++++++++++++
 tb/tb_trap_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the M-mode trap sequencer.
package trap_ctrl_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CAUSE_W = 4;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_BOOT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_TRAP     = 3'd2,
    ST_MRET     = 3'd3,
    ST_REDIRECT = 3'd4
  } trap_state_t;

  // Source of the fetch redirect address
  typedef enum logic [1:0] {
    RSEL_BOOT  = 2'd0,
    RSEL_MTVEC = 2'd1,
    RSEL_MEPC  = 2'd2
  } redirect_sel_t;

  // Synchronous exception codes (mcause[3:0], interrupt bit clear)
  localparam logic [CAUSE_W-1:0] EXC_INSN_MISALIGNED  = 4'd0;
  localparam logic [CAUSE_W-1:0] EXC_INSN_ACCESS      = 4'd1;
  localparam logic [CAUSE_W-1:0] EXC_ILLEGAL_INSN     = 4'd2;
  localparam logic [CAUSE_W-1:0] EXC_BREAKPOINT       = 4'd3;
  localparam logic [CAUSE_W-1:0] EXC_LOAD_MISALIGNED  = 4'd4;
  localparam logic [CAUSE_W-1:0] EXC_LOAD_ACCESS      = 4'd5;
  localparam logic [CAUSE_W-1:0] EXC_STORE_MISALIGNED = 4'd6;
  localparam logic [CAUSE_W-1:0] EXC_STORE_ACCESS     = 4'd7;
  localparam logic [CAUSE_W-1:0] EXC_ECALL_M          = 4'd11;

  // mcause for the machine timer interrupt
  localparam logic [XLEN-1:0] IRQ_M_TIMER_CAUSE = 32'h8000_0007;

  // State presented to the CSR file on trap entry
  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] val;
  } trap_info_t;

  // States in which younger pipeline instructions must be killed
  function automatic logic is_flush_state(trap_state_t s);
    return (s == ST_TRAP) || (s == ST_MRET) || (s == ST_REDIRECT);
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Commit-stage, CSR-file and fetch-redirect signals around the trap sequencer.
interface trap_ctrl_if;
  import trap_ctrl_pkg::*;

  logic                commit_valid;
  logic [XLEN-1:0]     commit_pc;
  logic                exc_valid;
  logic [CAUSE_W-1:0]  exc_cause;
  logic [XLEN-1:0]     exc_tval;
  logic                mret_req;
  logic                timer_irq;
  logic                mie_mtie;
  logic                mstatus_mie;
  logic [XLEN-1:0]     mtvec_in;
  logic [XLEN-1:0]     mepc_in;

  logic                trap_enter;
  logic [XLEN-1:0]     trap_cause;
  logic [XLEN-1:0]     trap_pc;
  logic [XLEN-1:0]     trap_val;
  logic                mret_exec;
  logic                flush;
  logic                redirect_valid;
  logic [XLEN-1:0]     redirect_pc;

  // Pipeline / CSR-file side
  modport master (
    output commit_valid, commit_pc, exc_valid, exc_cause, exc_tval, mret_req,
    output timer_irq, mie_mtie, mstatus_mie, mtvec_in, mepc_in,
    input  trap_enter, trap_cause, trap_pc, trap_val, mret_exec, flush,
    input  redirect_valid, redirect_pc
  );

  // Trap sequencer side
  modport slave (
    input  commit_valid, commit_pc, exc_valid, exc_cause, exc_tval, mret_req,
    input  timer_irq, mie_mtie, mstatus_mie, mtvec_in, mepc_in,
    output trap_enter, trap_cause, trap_pc, trap_val, mret_exec, flush,
    output redirect_valid, redirect_pc
  );

endinterface

// File: rtl/trap_ctrl.sv
// Trap sequencer: turns commit-stage exceptions, mret and the machine timer
// interrupt into CSR-file pulses, a pipeline flush and a fetch redirect.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter logic [31:0] BOOT_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  trap_ctrl_if.slave  bus
);

  trap_state_t   state_q, state_d;
  redirect_sel_t sel_q, sel_d;
  trap_info_t    info_q, info_d;
  logic          trap_enter_q, trap_enter_d;
  logic          mret_exec_q, mret_exec_d;
  logic          flush_q, flush_d;
  logic          rv_q, rv_d;
  logic          irq;
  logic [XLEN-1:0] redirect_pc;

  // Interrupt is taken only when both the source and the global enable are set
  assign irq = bus.timer_irq & bus.mie_mtie & bus.mstatus_mie;

  // Next state and next-cycle outputs
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    info_d  = '0;
    rv_d    = 1'b0;
    case (state_q)
      // Hold BOOT for one visible redirect cycle after reset release
      ST_BOOT: begin
        if (rv_q) begin
          state_d = ST_IDLE;
        end else begin
          rv_d  = 1'b1;
          sel_d = RSEL_BOOT;
        end
      end
      // Interrupt beats exception; the interrupted instruction is not retired
      ST_IDLE: begin
        if (bus.commit_valid) begin
          if (irq) begin
            state_d = ST_TRAP;
            info_d  = '{cause: IRQ_M_TIMER_CAUSE, pc: bus.commit_pc, val: '0};
          end else if (bus.exc_valid) begin
            state_d = ST_TRAP;
            info_d  = '{cause: XLEN'(bus.exc_cause), pc: bus.commit_pc, val: bus.exc_tval};
          end else if (bus.mret_req) begin
            state_d = ST_MRET;
          end
        end
      end
      ST_TRAP: begin
        state_d = ST_REDIRECT;
        sel_d   = RSEL_MTVEC;
        rv_d    = 1'b1;
      end
      ST_MRET: begin
        state_d = ST_REDIRECT;
        sel_d   = RSEL_MEPC;
        rv_d    = 1'b1;
      end
      ST_REDIRECT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
    trap_enter_d = (state_d == ST_TRAP);
    mret_exec_d  = (state_d == ST_MRET);
    flush_d      = is_flush_state(state_d);
  end

  // State and registered outputs; reset drops every pulse immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BOOT;
      sel_q        <= RSEL_BOOT;
      info_q       <= '0;
      trap_enter_q <= 1'b0;
      mret_exec_q  <= 1'b0;
      flush_q      <= 1'b0;
      rv_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      info_q       <= info_d;
      trap_enter_q <= trap_enter_d;
      mret_exec_q  <= mret_exec_d;
      flush_q      <= flush_d;
      rv_q         <= rv_d;
    end
  end

  // Redirect target reads mtvec/mepc live so a CSR write from the prior cycle is seen
  always_comb begin
    redirect_pc = '0;
    if (rv_q) begin
      case (sel_q)
        RSEL_MTVEC: redirect_pc = bus.mtvec_in;
        RSEL_MEPC:  redirect_pc = bus.mepc_in;
        default:    redirect_pc = BOOT_PC;
      endcase
    end
  end

  assign bus.trap_enter     = trap_enter_q;
  assign bus.trap_cause     = info_q.cause;
  assign bus.trap_pc        = info_q.pc;
  assign bus.trap_val       = info_q.val;
  assign bus.mret_exec      = mret_exec_q;
  assign bus.flush          = flush_q;
  assign bus.redirect_valid = rv_q;
  assign bus.redirect_pc    = redirect_pc;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl.
module tb_trap_ctrl;
  import trap_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  trap_ctrl_if bus ();

  trap_ctrl #(.BOOT_PC(32'h8000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.commit_valid = 1'b0;
    bus.commit_pc    = '0;
    bus.exc_valid    = 1'b0;
    bus.exc_cause    = '0;
    bus.exc_tval     = '0;
    bus.mret_req     = 1'b0;
    bus.timer_irq    = 1'b0;
  endtask

  initial begin
    int n_trap;
    int n_rv;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle_inputs();
    bus.mie_mtie    = 1'b0;
    bus.mstatus_mie = 1'b0;
    bus.mtvec_in    = 32'h0000_0200;
    bus.mepc_in     = 32'h0000_0108;

    // Reset state
    step(); step();
    chk("rst_rv", 32'(bus.redirect_valid), 32'd0);
    chk("rst_flush", 32'(bus.flush), 32'd0);
    chk("rst_trap_enter", 32'(bus.trap_enter), 32'd0);
    chk("rst_cause", bus.trap_cause, 32'd0);

    // Boot redirect for exactly one cycle
    rst_n = 1'b1;
    step();
    chk("boot_rv", 32'(bus.redirect_valid), 32'd1);
    chk("boot_pc", bus.redirect_pc, 32'h8000_0000);
    chk("boot_flush", 32'(bus.flush), 32'd0);
    step();
    chk("boot_rv_drop", 32'(bus.redirect_valid), 32'd0);
    step();

    // Synchronous exception; inputs kept asserted during TRAP must be ignored
    bus.commit_valid = 1'b1;
    bus.commit_pc    = 32'h0000_0100;
    bus.exc_valid    = 1'b1;
    bus.exc_cause    = EXC_ILLEGAL_INSN;
    bus.exc_tval     = 32'h0000_DEAD;
    step();
    chk("exc_enter", 32'(bus.trap_enter), 32'd1);
    chk("exc_cause", bus.trap_cause, 32'h0000_0002);
    chk("exc_pc", bus.trap_pc, 32'h0000_0100);
    chk("exc_val", bus.trap_val, 32'h0000_DEAD);
    chk("exc_flush", 32'(bus.flush), 32'd1);
    chk("exc_rv", 32'(bus.redirect_valid), 32'd0);
    step();
    idle_inputs();
    chk("exc_enter_drop", 32'(bus.trap_enter), 32'd0);
    chk("exc_cause_clr", bus.trap_cause, 32'd0);
    chk("exc_redir_rv", 32'(bus.redirect_valid), 32'd1);
    chk("exc_redir_pc", bus.redirect_pc, 32'h0000_0200);
    chk("exc_redir_flush", 32'(bus.flush), 32'd1);
    // mtvec is read live in the redirect cycle
    bus.mtvec_in = 32'h0000_0300;
    #1;
    chk("exc_redir_live", bus.redirect_pc, 32'h0000_0300);
    bus.mtvec_in = 32'h0000_0200;
    step();
    chk("exc_idle_flush", 32'(bus.flush), 32'd0);
    chk("exc_idle_rv", 32'(bus.redirect_valid), 32'd0);

    // Interrupt outranks a simultaneous exception
    bus.timer_irq    = 1'b1;
    bus.mie_mtie     = 1'b1;
    bus.mstatus_mie  = 1'b1;
    bus.commit_valid = 1'b1;
    bus.commit_pc    = 32'h0000_0104;
    bus.exc_valid    = 1'b1;
    bus.exc_cause    = EXC_LOAD_ACCESS;
    bus.exc_tval     = 32'h0000_BEEF;
    step();
    idle_inputs();
    chk("irq_enter", 32'(bus.trap_enter), 32'd1);
    chk("irq_cause", bus.trap_cause, 32'h8000_0007);
    chk("irq_pc", bus.trap_pc, 32'h0000_0104);
    chk("irq_val", bus.trap_val, 32'd0);
    step();
    chk("irq_redir_pc", bus.redirect_pc, 32'h0000_0200);
    step();

    // mret
    bus.commit_valid = 1'b1;
    bus.mret_req     = 1'b1;
    bus.commit_pc    = 32'h0000_0180;
    step();
    idle_inputs();
    chk("mret_exec", 32'(bus.mret_exec), 32'd1);
    chk("mret_no_trap", 32'(bus.trap_enter), 32'd0);
    chk("mret_flush", 32'(bus.flush), 32'd1);
    step();
    chk("mret_exec_drop", 32'(bus.mret_exec), 32'd0);
    chk("mret_redir_rv", 32'(bus.redirect_valid), 32'd1);
    chk("mret_redir_pc", bus.redirect_pc, 32'h0000_0108);
    chk("mret_redir_flush", 32'(bus.flush), 32'd1);
    step();
    chk("mret_idle_flush", 32'(bus.flush), 32'd0);

    // Pending irq with commit_valid low waits
    bus.timer_irq   = 1'b1;
    bus.mie_mtie    = 1'b1;
    bus.mstatus_mie = 1'b1;
    n_trap = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.trap_enter) n_trap++;
    end
    chk("irq_wait_commit", 32'(n_trap), 32'd0);

    // Globally masked interrupt is never taken, then taken once unmasked
    bus.mstatus_mie = 1'b0;
    n_trap = 0;
    for (int i = 0; i < 20; i++) begin
      bus.commit_valid = 1'b1;
      bus.commit_pc    = 32'h0000_1000 + 32'(i * 4);
      step();
      if (bus.trap_enter || bus.flush) n_trap++;
    end
    chk("masked_no_trap", 32'(n_trap), 32'd0);
    bus.mstatus_mie = 1'b1;
    bus.commit_pc   = 32'h0000_2000;
    step();
    idle_inputs();
    chk("unmask_enter", 32'(bus.trap_enter), 32'd1);
    chk("unmask_cause", bus.trap_cause, 32'h8000_0007);
    chk("unmask_pc", bus.trap_pc, 32'h0000_2000);
    step(); step();

    // Reset asserted during TRAP
    bus.commit_valid = 1'b1;
    bus.commit_pc    = 32'h0000_0140;
    bus.exc_valid    = 1'b1;
    bus.exc_cause    = EXC_ECALL_M;
    step();
    idle_inputs();
    chk("rst_trap_pre", 32'(bus.trap_enter), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_trap_drop", 32'(bus.trap_enter), 32'd0);
    chk("rst_trap_flush", 32'(bus.flush), 32'd0);
    chk("rst_trap_cause", bus.trap_cause, 32'd0);
    step(); step();
    rst_n = 1'b1;
    n_trap = 0;
    n_rv   = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.trap_enter || bus.mret_exec) n_trap++;
      if (bus.redirect_valid) begin
        n_rv++;
        chk("rst_boot_pc", bus.redirect_pc, 32'h8000_0000);
      end
    end
    chk("rst_no_pulse", 32'(n_trap), 32'd0);
    chk("rst_one_redirect", 32'(n_rv), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
